map_access_arbiter: RTL and testbench

- Shares the single-port synchronous map RAM between the graphics renderer (read-only) and the world/robot updater (read/write).
- Schedules world updates: one `world_tick` every TICK_FRAMES frames, issued at the start of vertical blank.
- Graphics has absolute priority while `video_on`=1. The world may only access the RAM during blanking, under a request/grant handshake.
- Sits between `world`, `graphics`, `vga_sync` and the map RAM. Everything runs in the clock_50 domain.

---
 rtl/map_pkg.sv | 24 ++
 rtl/frame_ticker.sv | 50 +++++
 rtl/map_access_arbiter.sv | 154 +++++++++++++++
 tb/tb_map_access_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// Shared definitions for the map RAM access path: widths, cell codes and
// the arbitration state encoding.
package map_pkg;

  localparam int MAP_ADDR_W      = 9;
  localparam int MAP_DATA_W      = 4;
  localparam int TICK_FRAMES_DEF = 30;
  localparam int FRAME_CNT_W     = 8;

  typedef enum logic [3:0] {
    CELL_EMPTY = 4'h0,
    CELL_WALL  = 4'h1,
    CELL_DIRT  = 4'h2,
    CELL_ROBOT = 4'h3,
    CELL_GOAL  = 4'h4
  } cell_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TICK  = 2'd1,
    S_WORLD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/frame_ticker.sv
// Detects the vsync falling edge and raises a one-cycle due strobe on every
// TICK_FRAMES-th frame start.
module frame_ticker
  import map_pkg::*;
#(
  parameter int TICK_FRAMES = TICK_FRAMES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vga_vs_i,
  output logic tick_due_o
);

  localparam logic [FRAME_CNT_W-1:0] LAST_FRAME = FRAME_CNT_W'(TICK_FRAMES - 1);

  logic                   vs_q;
  logic                   frame_start_s;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_d;

  assign frame_start_s = vs_q & ~vga_vs_i;

  // Frame counter advance and due strobe on each vsync falling edge.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    tick_due_o  = 1'b0;
    if (frame_start_s) begin
      if (frame_cnt_q == LAST_FRAME) begin
        frame_cnt_d = {FRAME_CNT_W{1'b0}};
        tick_due_o  = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // vs_q resets high so a low vsync at reset release still counts as an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_q        <= 1'b1;
      frame_cnt_q <= {FRAME_CNT_W{1'b0}};
    end else begin
      vs_q        <= vga_vs_i;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: rtl/map_access_arbiter.sv
// Shares the single-port map RAM between graphics (priority while video is on)
// and the world updater (blanking only), and schedules world update ticks.
module map_access_arbiter
  import map_pkg::*;
#(
  parameter int ADDR_W      = MAP_ADDR_W,
  parameter int DATA_W      = MAP_DATA_W,
  parameter int TICK_FRAMES = TICK_FRAMES_DEF
) (
  input  logic              clock_50,
  input  logic              reset_key,
  input  logic              video_on,
  input  logic              vga_vs,
  input  logic              gfx_rd_en,
  input  logic [ADDR_W-1:0] gfx_addr,
  output logic [DATA_W-1:0] gfx_rdata,
  output logic              gfx_rvalid,
  input  logic              wld_req,
  input  logic              wld_we,
  input  logic [ADDR_W-1:0] wld_addr,
  input  logic [DATA_W-1:0] wld_wdata,
  input  logic              wld_done,
  output logic              wld_gnt,
  output logic [DATA_W-1:0] wld_rdata,
  output logic              wld_rvalid,
  output logic              world_tick,
  output logic              overrun,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  arb_state_e        state_q, state_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              tick_due_s;
  logic              gfx_rvalid_q, wld_rvalid_q;
  logic [DATA_W-1:0] gfx_rdata_q, wld_rdata_q;

  frame_ticker #(
    .TICK_FRAMES(TICK_FRAMES)
  ) u_frame_ticker (
    .clk_i      (clock_50),
    .rst_ni     (reset_key),
    .vga_vs_i   (vga_vs),
    .tick_due_o (tick_due_s)
  );

  // Scheduling FSM: a due frame while an update is still running only flags overrun.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (tick_due_s) begin
          if (busy_q) begin
            overrun_d = 1'b1;
          end else begin
            state_d = S_TICK;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TICK: begin
        busy_d  = 1'b1;
        state_d = S_WORLD;
        if (tick_due_s) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
      end
      S_WORLD: begin
        if (wld_done) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WORLD;
        end
        if (tick_due_s) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, busy and sticky overrun registers.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign world_tick = (state_q == S_TICK);
  assign overrun    = overrun_q;
  assign wld_gnt    = wld_req & (state_q == S_WORLD) & ~video_on;

  // RAM port mux: graphics owns the port unless the world holds a grant.
  always_comb begin
    ram_addr  = gfx_addr;
    ram_we    = 1'b0;
    ram_wdata = {DATA_W{1'b0}};
    if (wld_gnt) begin
      ram_addr  = wld_addr;
      ram_we    = wld_we;
      ram_wdata = wld_wdata;
    end else begin
      ram_addr  = gfx_addr;
      ram_we    = 1'b0;
      ram_wdata = {DATA_W{1'b0}};
    end
  end

  // Read-valid tracking; data registers hold the last returned word between reads.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      gfx_rvalid_q <= 1'b0;
      wld_rvalid_q <= 1'b0;
      gfx_rdata_q  <= {DATA_W{1'b0}};
      wld_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      gfx_rvalid_q <= gfx_rd_en & ~wld_gnt;
      wld_rvalid_q <= wld_gnt & ~wld_we;
      if (gfx_rvalid_q) begin
        gfx_rdata_q <= ram_rdata;
      end
      if (wld_rvalid_q) begin
        wld_rdata_q <= ram_rdata;
      end
    end
  end

  // RAM data arrives one cycle after the access, so pass it straight through while valid.
  assign gfx_rvalid = gfx_rvalid_q;
  assign wld_rvalid = wld_rvalid_q;
  assign gfx_rdata  = gfx_rvalid_q ? ram_rdata : gfx_rdata_q;
  assign wld_rdata  = wld_rvalid_q ? ram_rdata : wld_rdata_q;

endmodule

// File: tb/tb_map_access_arbiter.sv
// Randomised bench for map_access_arbiter: a frame-level reference model predicts
// ticks, grants, overrun and read data, with directed literal checks on top.
module tb_map_access_arbiter;

  localparam int TICK      = 3;
  localparam int FRAME_LEN = 40;
  localparam int VID_END   = 24;
  localparam int VS_BEG    = 26;
  localparam int VS_END    = 29;

  logic       clock_50 = 1'b0;
  logic       reset_key, video_on, vga_vs, gfx_rd_en, wld_req, wld_we, wld_done;
  logic [8:0] gfx_addr, wld_addr, ram_addr;
  logic [3:0] wld_wdata, gfx_rdata, wld_rdata, ram_wdata, ram_rdata;
  logic       gfx_rvalid, wld_gnt, wld_rvalid, world_tick, overrun, ram_we;

  int checks = 0;
  int errors = 0;
  int fc;
  int dut_ticks = 0;

  always #10 clock_50 = ~clock_50;

  map_access_arbiter #(.ADDR_W(9), .DATA_W(4), .TICK_FRAMES(TICK)) dut (
    .clock_50(clock_50), .reset_key(reset_key), .video_on(video_on), .vga_vs(vga_vs),
    .gfx_rd_en(gfx_rd_en), .gfx_addr(gfx_addr), .gfx_rdata(gfx_rdata), .gfx_rvalid(gfx_rvalid),
    .wld_req(wld_req), .wld_we(wld_we), .wld_addr(wld_addr), .wld_wdata(wld_wdata),
    .wld_done(wld_done), .wld_gnt(wld_gnt), .wld_rdata(wld_rdata), .wld_rvalid(wld_rvalid),
    .world_tick(world_tick), .overrun(overrun), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [3:0] init_val(input logic [8:0] a);
    return a[3:0] ^ a[7:4] ^ {3'b000, a[8]};
  endfunction

  // Map RAM: synchronous, read-first, one-cycle latency.
  logic [3:0] mem   [512];
  bit         mem_w [512];
  always @(posedge clock_50) begin
    ram_rdata <= mem_w[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
    if (ram_we) begin
      mem[ram_addr]   <= ram_wdata;
      mem_w[ram_addr] <= 1'b1;
    end
  end

  // Reference model: counts vsync edges, every TICK-th is due; one update window at a time.
  logic [3:0] ref_mem [512];
  bit         ref_w   [512];
  logic m_vs_prev = 1'b1, m_tick = 1'b0, m_upd = 1'b0, m_ovr = 1'b0, m_last_gnt = 1'b0;
  logic exp_grv = 1'b0, exp_wrv = 1'b0;
  logic [3:0] exp_grd = 4'h0, exp_wrd = 4'h0;
  int   m_edges = 0, m_ticks = 0;
  logic m_fs, m_due, m_gnt;

  function automatic logic [3:0] ref_rd(input logic [8:0] a);
    return ref_w[a] ? ref_mem[a] : init_val(a);
  endfunction

  assign m_fs  = m_vs_prev & ~vga_vs;
  assign m_due = m_fs && (((m_edges + 1) % TICK) == 0);
  assign m_gnt = wld_req & m_upd & ~video_on;

  always @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      m_vs_prev <= 1'b1; m_tick <= 1'b0; m_upd <= 1'b0; m_ovr <= 1'b0;
      m_last_gnt <= 1'b0; exp_grv <= 1'b0; exp_wrv <= 1'b0; m_edges <= 0;
    end else begin
      m_vs_prev  <= vga_vs;
      if (m_fs) m_edges <= m_edges + 1;
      m_tick     <= m_due & ~(m_tick | m_upd);
      if (m_due & (m_tick | m_upd)) m_ovr <= 1'b1;
      if (m_due & ~(m_tick | m_upd)) m_ticks <= m_ticks + 1;
      m_upd      <= m_tick | (m_upd & ~wld_done);
      m_last_gnt <= m_gnt;
      exp_wrv    <= m_gnt & ~wld_we;
      exp_grv    <= gfx_rd_en & ~m_gnt;
      if (m_gnt & ~wld_we) exp_wrd <= ref_rd(wld_addr);
      if (gfx_rd_en & ~m_gnt) exp_grd <= ref_rd(gfx_addr);
      if (m_gnt & wld_we) begin
        ref_mem[wld_addr] <= wld_wdata;
        ref_w[wld_addr]   <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic egnt;
    egnt = wld_req & m_upd & ~video_on;
    chk("world_tick", 32'(world_tick), 32'(m_tick));
    chk("wld_gnt", 32'(wld_gnt), 32'(egnt));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("gfx_rvalid", 32'(gfx_rvalid), 32'(exp_grv));
    chk("wld_rvalid", 32'(wld_rvalid), 32'(exp_wrv));
    chk("ram_we", 32'(ram_we), 32'(egnt & wld_we));
    chk("ram_addr", 32'(ram_addr), 32'(egnt ? wld_addr : gfx_addr));
    chk("ram_wdata", 32'(ram_wdata), 32'(egnt ? wld_wdata : 4'h0));
    if (exp_grv) chk("gfx_rdata", 32'(gfx_rdata), 32'(exp_grd));
    if (exp_wrv) chk("wld_rdata", 32'(wld_rdata), 32'(exp_wrd));
    if (world_tick === 1'b1) dut_ticks++;
  endtask

  // One clock: compare on the falling edge, then drive the next cycle's frame timing.
  task automatic tick_cycle();
    @(negedge clock_50);
    compare_all();
    @(posedge clock_50);
    #2;
    fc        = (fc + 1) % FRAME_LEN;
    video_on  = (fc < VID_END);
    vga_vs    = !(fc >= VS_BEG && fc < VS_END);
    wld_done  = 1'b0;
    gfx_rd_en = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (!m_tick && n < 200) begin
      tick_cycle();
      gfx_rd_en = 1'($urandom_range(0, 1));
      gfx_addr  = 9'($urandom_range(0, 511));
      n++;
    end
    if (!m_tick) begin
      checks++; errors++;
      $display("FAIL wait_tick: no world tick within 200 cycles");
    end
  endtask

  task automatic fail_timeout(input string nm);
    checks++; errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  initial begin
    int cd, t0, edges, ops, t6;
    int exp_cum [7] = '{0, 0, 1, 1, 1, 2, 2};
    reset_key = 1'b1; video_on = 1'b0; vga_vs = 1'b1; gfx_rd_en = 1'b0; gfx_addr = 9'h000;
    wld_req = 1'b0; wld_we = 1'b0; wld_addr = 9'h000; wld_wdata = 4'h0; wld_done = 1'b0;
    fc = FRAME_LEN - 3;
    #1 reset_key = 1'b0;
    tick_cycle();
    #1;
    chk("reset_world_tick", 32'(world_tick), 32'd0);
    chk("reset_gfx_rvalid", 32'(gfx_rvalid), 32'd0);
    chk("reset_wld_rvalid", 32'(wld_rvalid), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_gfx_rdata", 32'(gfx_rdata), 32'd0);
    chk("reset_wld_rdata", 32'(wld_rdata), 32'd0);
    tick_cycle();
    reset_key = 1'b1;

    // Seven frames, update finishes 10 cycles after each tick.
    cd = 0;
    for (int f = 0; f < 7; f++) begin
      for (int c = 0; c < FRAME_LEN; c++) begin
        tick_cycle();
        gfx_rd_en = 1'($urandom_range(0, 1));
        gfx_addr  = 9'($urandom_range(0, 511));
        if (m_tick) cd = 10;
        else if (cd > 0) begin
          cd--;
          if (cd == 0) wld_done = 1'b1;
        end
      end
      chk("ticks_after_edge", 32'(dut_ticks), 32'(exp_cum[f]));
    end
    chk("model_ticks_7_edges", 32'(m_ticks), 32'd2);
    chk("no_overrun_7_edges", 32'(overrun), 32'd0);

    // World write then read of 0x05A in blanking.
    wait_tick();
    tick_cycle();
    wld_req = 1'b1; wld_we = 1'b1; wld_addr = 9'h05A; wld_wdata = 4'h7;
    #1;
    chk("wr_gnt", 32'(wld_gnt), 32'd1);
    chk("wr_ram_we", 32'(ram_we), 32'd1);
    chk("wr_ram_addr", 32'(ram_addr), 32'h05A);
    tick_cycle();
    wld_we = 1'b0;
    tick_cycle();
    wld_req = 1'b0;
    #1;
    chk("rd_wld_rvalid", 32'(wld_rvalid), 32'd1);
    chk("rd_wld_rdata", 32'(wld_rdata), 32'h7);

    // Video rises while a world write is pending: no grant, graphics sees old data.
    for (int i = 0; i < 50 && fc != FRAME_LEN - 1; i++) tick_cycle();
    tick_cycle();
    wld_req = 1'b1; wld_we = 1'b1; wld_addr = 9'h05A; wld_wdata = 4'h3;
    #1;
    chk("video_gnt_drop", 32'(wld_gnt), 32'd0);
    chk("video_ram_we", 32'(ram_we), 32'd0);
    tick_cycle();
    gfx_rd_en = 1'b1; gfx_addr = 9'h05A;
    tick_cycle();
    #1;
    chk("video_gfx_rvalid", 32'(gfx_rvalid), 32'd1);
    chk("video_gfx_rdata", 32'(gfx_rdata), 32'h7);
    for (int i = 0; i < 60 && !m_last_gnt; i++) tick_cycle();
    if (!m_last_gnt) fail_timeout("pending_write_grant");
    wld_we = 1'b0;
    tick_cycle();
    wld_req = 1'b0;
    #1;
    chk("resumed_write_rvalid", 32'(wld_rvalid), 32'd1);
    chk("resumed_write_rdata", 32'(wld_rdata), 32'h3);
    wld_done = 1'b1;

    // Withhold done past the next due edge.
    wait_tick();
    tick_cycle();
    t0 = dut_ticks;
    for (int i = 0; i < 125; i++) tick_cycle();
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("no_tick_while_busy", 32'(dut_ticks - t0), 32'd0);
    wld_done = 1'b1;
    for (int i = 0; i < 3; i++) tick_cycle();
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Asynchronous reset between edges in the middle of an update.
    wait_tick();
    tick_cycle();
    wld_req = 1'b1; wld_we = 1'b1; wld_addr = 9'h0A0; wld_wdata = 4'h9;
    #1;
    chk("pre_reset_gnt", 32'(wld_gnt), 32'd1);
    #3 reset_key = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(wld_gnt), 32'd0);
    chk("async_rst_tick", 32'(world_tick), 32'd0);
    chk("async_rst_gfx_rvalid", 32'(gfx_rvalid), 32'd0);
    chk("async_rst_wld_rvalid", 32'(wld_rvalid), 32'd0);
    chk("async_rst_overrun", 32'(overrun), 32'd0);
    chk("async_rst_ram_we", 32'(ram_we), 32'd0);
    wld_req = 1'b0;
    tick_cycle();
    reset_key = 1'b1;
    t0 = dut_ticks; edges = 0; t6 = 0;
    for (int i = 0; i < 140 && edges < TICK; i++) begin
      tick_cycle();
      if (fc == VS_BEG) edges++;
      if (t6 == 1) begin
        t6 = 2; wld_req = 1'b0;
        #1;
        chk("idle_gfx_rvalid", 32'(gfx_rvalid), 32'd1);
        chk("idle_gfx_rdata", 32'(gfx_rdata), 32'h3);
      end
      if (fc == 30 && t6 == 0) begin
        t6 = 1; gfx_rd_en = 1'b1; gfx_addr = 9'h05A;
        wld_req = 1'b1; wld_we = 1'b0; wld_addr = 9'h011;
        #1;
        chk("idle_no_gnt", 32'(wld_gnt), 32'd0);
      end
    end
    if (edges < TICK) fail_timeout("post_reset_edges");
    chk("no_early_tick", 32'(dut_ticks - t0), 32'd0);
    tick_cycle();
    tick_cycle();
    chk("first_tick_after_reset", 32'(dut_ticks - t0), 32'd1);

    // Random soak with a world agent that holds requests until granted.
    ops = 0;
    for (int i = 0; i < 40 * FRAME_LEN; i++) begin
      tick_cycle();
      gfx_rd_en = 1'($urandom_range(0, 1));
      gfx_addr  = 9'h050 + 9'($urandom_range(0, 15));
      if (m_tick) ops = $urandom_range(1, 6);
      if (!(wld_req && !m_last_gnt)) begin
        wld_req = 1'b0;
        if (m_upd && ops > 0 && $urandom_range(0, 3) != 0) begin
          wld_req   = 1'b1;
          wld_we    = 1'($urandom_range(0, 1));
          wld_addr  = 9'h050 + 9'($urandom_range(0, 15));
          wld_wdata = 4'($urandom);
          ops--;
        end else if (m_upd && ops == 0 && $urandom_range(0, 7) == 0) begin
          wld_done = 1'b1;
        end else if (!m_upd && $urandom_range(0, 31) == 0) begin
          wld_done = 1'b1;
        end
      end
    end
    tick_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
